// File: rtl/rs_syndrome_serial.sv
// Streaming RS(N,K) syndrome calculator over GF(2^M): Horner evaluation of
// the received polynomial at alpha^(FCR+j), j = 0..TWO_T-1, one symbol per cycle.
module rs_syndrome_serial #(
  parameter int unsigned M         = 3,
  parameter int unsigned N         = 7,
  parameter int unsigned K         = 5,
  parameter int unsigned FCR       = 1,
  parameter logic [M:0]  PRIM_POLY = 4'b1011
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M-1:0]           in_sym,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(N-K)*M-1:0]     out_syn,
  output logic                   out_zero,
  output logic                   out_frame_err
);

  localparam int unsigned TWO_T = N - K;
  localparam int unsigned SW    = TWO_T * M;
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;

  // Shift-and-add GF(2^M) multiply; with one operand constant this folds
  // down to a small XOR network.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = x[M-1] ? ((x << 1) ^ PRIM_POLY[M-1:0]) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [SW-1:0] calc_betas();
    logic [SW-1:0]  b;
    logic [M-1:0]   p;
    b = '0;
    p = M'(1);
    for (int unsigned e = 0; e < FCR; e++) p = gf_mul(p, M'(2));
    for (int unsigned j = 0; j < TWO_T; j++) begin
      b[j*M +: M] = p;
      p = gf_mul(p, M'(2));
    end
    return b;
  endfunction

  localparam logic [SW-1:0] BETAS = calc_betas();

  logic [CW-1:0] cnt;
  logic [SW-1:0] acc;
  logic [SW-1:0] acc_next;
  logic          take;
  logic          idle;
  logic          last_pos;
  logic          frame_end;
  logic          frame_err;

  assign in_ready  = !out_valid || out_ready;
  assign take      = in_valid && in_ready;
  assign idle      = (cnt == '0);
  assign last_pos  = (cnt == CW'(N - 1));
  assign frame_end = take && !clr && (last_pos || in_last);
  assign frame_err = (in_last != last_pos);

  // First symbol of a frame overwrites the accumulators outright.
  always_comb begin
    acc_next = '0;
    for (int unsigned j = 0; j < TWO_T; j++) begin
      acc_next[j*M +: M] = (idle ? '0 : gf_mul(acc[j*M +: M], BETAS[j*M +: M])) ^ in_sym;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (take) begin
      if (frame_end) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        acc <= acc_next;
      end
    end
  end

  // A completing frame reloads the result even while the previous one is
  // being accepted, which keeps back-to-back frames at full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_syn       <= '0;
      out_zero      <= 1'b0;
      out_frame_err <= 1'b0;
    end else if (frame_end) begin
      out_valid     <= 1'b1;
      out_syn       <= acc_next;
      out_zero      <= (acc_next == '0) && !frame_err;
      out_frame_err <= frame_err;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_serial.sv
// Randomized bench for rs_syndrome_serial: syndromes are predicted by direct
// polynomial evaluation using log/antilog tables built from the primitive polynomial.
module tb_rs_syndrome_serial;

  localparam int unsigned M         = 3;
  localparam int unsigned N         = 7;
  localparam int unsigned K         = 5;
  localparam int unsigned FCR       = 1;
  localparam logic [M:0]  PRIM_POLY = 4'b1011;
  localparam int unsigned TWO_T     = N - K;
  localparam int unsigned SW        = TWO_T * M;
  localparam int          Q         = 1 << M;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_sym;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_syn;
  logic          out_zero;
  logic          out_frame_err;

  rs_syndrome_serial #(
    .M(M), .N(N), .K(K), .FCR(FCR), .PRIM_POLY(PRIM_POLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_syn(out_syn),
    .out_zero(out_zero), .out_frame_err(out_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0] sym;
    logic         last;
    logic         is_clr;
  } stim_t;

  typedef struct {
    logic [SW-1:0] syn;
    logic          zero;
    logic          err;
  } exp_t;

  stim_t  stim_q[$];
  exp_t   exp_q[$];
  int     rx_q[$];
  int     alog[Q-1];
  int     lg[Q];
  int     checks = 0;
  int     errors = 0;
  int     valid_pct = 100;
  int     ready_pct = 100;
  logic [SW-1:0] last_syn;
  logic          last_zero;
  logic          last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[(lg[a] + lg[b]) % (Q - 1)];
  endfunction

  // S_(FCR+j) = sum over received symbols of v_d * alpha^((FCR+j)*d),
  // where the first received symbol carries the highest degree.
  function automatic exp_t model_result(input logic last_flag);
    exp_t r;
    int   s;
    int   deg;
    r.syn = '0;
    for (int j = 0; j < int'(TWO_T); j++) begin
      s = 0;
      for (int k = 0; k < rx_q.size(); k++) begin
        deg = rx_q.size() - 1 - k;
        s = s ^ gmul(rx_q[k], alog[((int'(FCR) + j) * deg) % (Q - 1)]);
      end
      r.syn[j*M +: M] = M'(s);
    end
    r.err  = (last_flag != (rx_q.size() == int'(N)));
    r.zero = (r.syn == '0) && !r.err;
    return r;
  endfunction

  task automatic push_sym(input int sym, input logic last);
    stim_t it;
    it.sym = M'(sym);
    it.last = last;
    it.is_clr = 1'b0;
    stim_q.push_back(it);
  endtask

  task automatic push_clr();
    stim_t it;
    it.sym = '0;
    it.last = 1'b0;
    it.is_clr = 1'b1;
    stim_q.push_back(it);
  endtask

  task automatic cycle();
    stim_t it;
    exp_t  r;
    logic  pend;
    @(negedge clk);
    out_ready = ($urandom_range(99) < ready_pct);
    in_valid = 1'b0;
    clr = 1'b0;
    in_sym = '0;
    in_last = 1'b0;
    if (stim_q.size() != 0 && $urandom_range(99) < valid_pct) begin
      it = stim_q[0];
      if (it.is_clr) begin
        clr = 1'b1;
        in_valid = 1'($urandom_range(1));
        in_sym = M'($urandom);
        in_last = 1'($urandom_range(1));
      end else begin
        in_valid = 1'b1;
        in_sym = it.sym;
        in_last = it.last;
      end
    end
    #1;
    pend = (exp_q.size() != 0);
    check("out_valid", out_valid, pend);
    check("in_ready", in_ready, !pend || out_ready);
    if (pend && out_ready) begin
      r = exp_q.pop_front();
      check("out_syn", out_syn, r.syn);
      check("out_zero", out_zero, r.zero);
      check("out_frame_err", out_frame_err, r.err);
      last_syn = out_syn;
      last_zero = out_zero;
      last_err = out_frame_err;
    end
    if (clr) begin
      rx_q.delete();
      void'(stim_q.pop_front());
    end else if (in_valid && (!pend || out_ready)) begin
      rx_q.push_back(int'(in_sym));
      void'(stim_q.pop_front());
      if (in_last || rx_q.size() == int'(N)) begin
        exp_q.push_back(model_result(in_last));
        rx_q.delete();
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int guard = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && guard < 3000) begin
      cycle();
      guard++;
    end
    check("drain_timeout", stim_q.size() + exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_syn"}, out_syn, 0);
    check({tag, "_out_zero"}, out_zero, 0);
    check({tag, "_out_frame_err"}, out_frame_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    int r;
    int len;
    x = 1;
    for (int i = 0; i < Q - 1; i++) begin
      alog[i] = x;
      lg[x] = i;
      x = x << 1;
      if (x >= Q) x = x ^ int'(PRIM_POLY);
    end
    lg[0] = 0;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sym = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // 1: all-zero codeword
    for (int i = 0; i < int'(N); i++) push_sym(0, i == int'(N) - 1);
    drain();
    check("tc1_syn", last_syn, 0);
    check("tc1_zero", last_zero, 1);
    check("tc1_err", last_err, 0);

    // 2: v_0 = 1
    for (int i = 0; i < int'(N); i++) push_sym(i == int'(N) - 1 ? 1 : 0, i == int'(N) - 1);
    drain();
    check("tc2_syn", last_syn, 6'b001_001);
    check("tc2_zero", last_zero, 0);

    // 3: v_1 = 1
    for (int i = 0; i < int'(N); i++) push_sym(i == int'(N) - 2 ? 1 : 0, i == int'(N) - 1);
    drain();
    check("tc3_syn", last_syn, 6'b100_010);

    // 4: two frames with consumer stalled, then released
    ready_pct = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < int'(N); i++) push_sym(int'($urandom_range(Q - 1)), i == int'(N) - 1);
    run_cycles(20);
    check("tc4_stalled", stim_q.size() != 0, 1);
    ready_pct = 100;
    drain();

    // 5: early in_last, then a clean frame; also an early all-zero frame
    for (int i = 0; i < 4; i++) push_sym(int'($urandom_range(Q - 1)), i == 3);
    drain();
    check("tc5_err", last_err, 1);
    for (int i = 0; i < 3; i++) push_sym(0, i == 2);
    drain();
    check("tc5_zero_short", last_zero, 0);
    for (int i = 0; i < int'(N); i++) push_sym(0, i == int'(N) - 1);
    drain();
    check("tc5_clean_err", last_err, 0);
    // full-length frame without in_last
    for (int i = 0; i < int'(N); i++) push_sym(int'($urandom_range(Q - 1)), 1'b0);
    drain();
    check("tc5_nolast_err", last_err, 1);

    // 6: clr after three symbols, then the v_1 frame
    for (int i = 0; i < 3; i++) push_sym(int'($urandom_range(1, Q - 1)), 1'b0);
    push_clr();
    for (int i = 0; i < int'(N); i++) push_sym(i == int'(N) - 2 ? 1 : 0, i == int'(N) - 1);
    drain();
    check("tc6_syn", last_syn, 6'b100_010);

    // 6b: reset mid-frame with a result pending
    ready_pct = 0;
    for (int i = 0; i < int'(N); i++) push_sym(int'($urandom_range(Q - 1)), i == int'(N) - 1);
    for (int i = 0; i < 3; i++) push_sym(int'($urandom_range(Q - 1)), 1'b0);
    run_cycles(12);
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_state("midreset");
    stim_q.delete(); exp_q.delete(); rx_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_pct = 100;
    for (int i = 0; i < int'(N); i++) push_sym(i == int'(N) - 1 ? 1 : 0, i == int'(N) - 1);
    drain();
    check("tc6_post_reset_syn", last_syn, 6'b001_001);

    // Random traffic with mixed framing, clr and backpressure
    for (int f = 0; f < 60; f++) begin
      valid_pct = 50 + int'($urandom_range(50));
      case ($urandom_range(2))
        0: ready_pct = 100;
        1: ready_pct = 50;
        default: ready_pct = 20;
      endcase
      r = int'($urandom_range(9));
      if (r == 0) begin
        for (int i = 0; i < int'(N); i++) push_sym(0, i == int'(N) - 1);
      end else if (r == 1) begin
        len = int'($urandom_range(1, N - 1));
        for (int i = 0; i < len; i++) push_sym(int'($urandom_range(Q - 1)), i == len - 1);
      end else if (r == 2) begin
        for (int i = 0; i < int'(N); i++) push_sym(int'($urandom_range(Q - 1)), 1'b0);
      end else if (r == 3) begin
        len = int'($urandom_range(0, N - 1));
        for (int i = 0; i < len; i++) push_sym(int'($urandom_range(Q - 1)), 1'b0);
        push_clr();
        for (int i = 0; i < int'(N); i++) push_sym(int'($urandom_range(Q - 1)), i == int'(N) - 1);
      end else begin
        for (int i = 0; i < int'(N); i++) push_sym(int'($urandom_range(Q - 1)), i == int'(N) - 1);
      end
      if ($urandom_range(3) == 0) drain();
    end
    drain();
    run_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
